rom_scan_ctrl: RTL and testbench
================================

# rom_scan_ctrl

Read sequencer for the byte-wide image ROM (registered read, one-cycle latency, two bytes per access at `a` and `a+1`, output forced to zero when not enabled). On `start` it walks the whole frame in address order, two pixels per read, and streams the pixel pairs out over a valid/ready interface with row/frame markers. A 2-entry skid FIFO absorbs the ROM latency, so downstream backpressure never loses or zeroes a read.

## Interface
- `IMG_W`, 640: pixels per row; must be even.
- `IMG_H`, 320: rows per frame.
- `ADDR_W`, 19: ROM address width.
- `BASE_ADDR`, 0: byte address of pixel (0,0).

- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a frame scan; sampled only in IDLE.
- `abort` in 1: synchronous cancel of a scan in progress.
- `busy` out 1: high in SCAN.
- `done` out 1: one-cycle pulse after the last pair is accepted.
- `rom_en` out 1: ROM read enable, one read per high cycle.
- `rom_addr` out ADDR_W: ROM byte address.
- `rom_data` in 32: ROM output; bits [15:8] = byte at addr, [7:0] = byte at addr+1; [31:16] ignored.
- `pix_valid` out 1: output pair valid.
- `pix_ready` in 1: downstream accepts; transfer = `pix_valid & pix_ready`.
- `pix_data` out 16: pixel pair, [15:8] left pixel, [7:0] right pixel.
- `pix_sof` out 1: qualifies the first pair of the frame.
- `pix_eol` out 1: qualifies the last pair of each row.
- `pix_eof` out 1: qualifies the last pair of the frame.

## Operation
- States: IDLE, SCAN, FINISH.
- IDLE: `start`=1 → SCAN. Issue address and output counters load `BASE_ADDR` and 0; FIFO empty.
- SCAN, issue side: `issue = (occ + inflight − pop) < 2` and reads remaining > 0. `pop` = transfer this cycle, `occ` = FIFO count (0..2), `inflight` = 1 if `rom_en` was high last cycle. On issue: `rom_en`=1 and the address advances by 2 after the cycle. Total reads N = IMG_W·IMG_H/2. The last address is `BASE_ADDR` + IMG_W·IMG_H − 2.
- SCAN, capture side: the cycle after each issue, `rom_data[15:0]` is pushed into the FIFO. Push and pop may happen in the same cycle. The FIFO never overflows, and the issue rule guarantees this.
- Output: `pix_valid` = (occ > 0). `pix_data` = FIFO head.
- Output counters `col` (0..IMG_W/2−1) and `row` (0..IMG_H−1) advance on each transfer.
- `pix_sof` = (row=0 & col=0). `pix_eol` = (col=IMG_W/2−1). `pix_eof` = eol & (row=IMG_H−1).
- Transfer of the eof pair → FINISH. FINISH lasts one cycle with `done`=1, then → IDLE.
- `start` in SCAN or FINISH is ignored.
- `abort`=1 in SCAN → IDLE next cycle: FIFO flushed, inflight read discarded, no `done`, `rom_en` forced 0 that cycle. `abort` in IDLE/FINISH has no effect. `abort` and `start` both high in IDLE: `start` wins.
- `rst` is asynchronous and may assert mid-scan. All state clears immediately. A scan needs a new `start`.
- `rom_en` is never high outside SCAN. `rom_addr` holds the next issue address and is stable while `rom_en`=0.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rom_en`=0, `rom_addr`=BASE_ADDR, `pix_valid`=0, `pix_data`=0, `pix_sof`/`pix_eol`/`pix_eof`=0, all counters 0.
- Let `start` be sampled in cycle 0:
  - Cycle 1: `rom_en` high, address BASE_ADDR.
  - Cycle 2: ROM data captured.
  - Cycle 3: first `pix_valid`. Latency from `rom_en` to `pix_valid` is 2 cycles.
- With `pix_ready` held high, throughput is one pair per cycle. `rom_en` is high cycles 1..N. The last transfer is in cycle N+2, `done` in cycle N+3, IDLE in cycle N+4.
- `pix_ready`=0 for k cycles: `rom_en` drops within 2 cycles and occ saturates at 2. After ready returns, data order is unchanged and nothing is duplicated or dropped.
- `pix_valid`/`pix_data`/markers hold stable while `pix_valid & !pix_ready`.

## Test plan
- Small frame: IMG_W=4, IMG_H=2, ROM bytes = address, ready=1; `start` at cycle 0 → expected response:
  - `rom_addr` 0,2,4,6 in cycles 1–4.
  - `pix_data` 0x0001, 0x0203, 0x0405, 0x0607 in cycles 3–6.
  - sof on the 1st pair, eol on the 2nd and 4th, eof on the 4th.
  - `done` in cycle 7.
- Backpressure: same frame with `pix_ready` low in cycles 3–7, then high → no more than 2 reads outstanding beyond the accepted pairs, and the same 4 pairs arrive in order. Checker: `rom_en` never high when occ + inflight − pop ≥ 2.
- Abort: `abort` at cycle 4 → IDLE at cycle 5, `rom_en`=0 from cycle 4, no `done`, FIFO empty. A new `start` then produces the full sequence from address 0.
- Async reset mid-scan: `rst` pulsed between edges at cycle 3 → outputs at reset values immediately, no further `rom_en`.
- Ignored start and random ready: `start` held high throughout with random `pix_ready` → exactly one frame per `start` accepted in IDLE. Default params give 102400 pairs, the last from address 204798, with eof on the final pair only.

Source files
------------

// File: rtl/rom_scan_ctrl_if.sv
// rom_scan_ctrl_if
// Bundles the ROM read port and the pixel-pair stream of rom_scan_ctrl.
//   rom_en    : ROM read enable, one read per high cycle
//   rom_addr  : ROM byte address
//   rom_data  : ROM output, [15:8] byte at addr, [7:0] byte at addr+1
//   pix_valid : pixel pair valid
//   pix_ready : downstream accepts the pair
//   pix_data  : pixel pair, [15:8] left, [7:0] right
//   pix_sof   : first pair of the frame
//   pix_eol   : last pair of a row
//   pix_eof   : last pair of the frame
// master = the controller, slave = ROM plus downstream consumer.
interface rom_scan_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [15:0]       pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;

    modport master (
        output rom_en, rom_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
        input  rom_data, pix_ready
    );

    modport slave (
        input  rom_en, rom_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
        output rom_data, pix_ready
    );
endinterface

// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl
// Walks the image ROM in address order, two pixels per read, and streams the
// pairs over a valid/ready port with sof/eol/eof markers. A 2-entry skid FIFO
// covers the one-cycle ROM latency so backpressure never loses a read.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : begin a frame scan (sampled in IDLE only)
//   abort : cancel a scan in progress
//   busy  : high while scanning
//   done  : one-cycle pulse after the last pair is accepted
//   bus   : ROM read port and pixel stream (master side)
//
// state  | meaning
// IDLE   | waiting for start
// SCAN   | issuing reads and streaming pairs
// FINISH | one-cycle done pulse after the eof pair
module rom_scan_ctrl #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 320,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    rom_scan_ctrl_if.master bus
);

    localparam int N_READS   = IMG_W * IMG_H / 2;
    localparam int RD_W      = $clog2(N_READS + 1);
    localparam int PAIRS_ROW = IMG_W / 2;
    localparam int COL_W     = (PAIRS_ROW > 1) ? $clog2(PAIRS_ROW) : 1;
    localparam int ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [RD_W-1:0]   RD_TOTAL = RD_W'(N_READS);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(PAIRS_ROW - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ADDR0    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_W-1:0]   rd_left;
    logic              inflight;
    logic [1:0]        occ;
    logic [15:0]       fifo_0, fifo_1;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;

    logic              pop, push, issue;
    logic [2:0]        pending;
    logic              unused_rom_hi;

    assign unused_rom_hi = ^bus.rom_data[31:16];

    // Output side
    assign bus.pix_valid = (occ != 2'd0);
    assign bus.pix_data  = bus.pix_valid ? fifo_0 : 16'h0000;
    assign bus.pix_sof   = bus.pix_valid && (row == '0) && (col == '0);
    assign bus.pix_eol   = bus.pix_valid && (col == COL_LAST);
    assign bus.pix_eof   = bus.pix_eol && (row == ROW_LAST);

    assign pop = bus.pix_valid & bus.pix_ready;

    // Reads already committed (queued + on the ROM) minus the one leaving now.
    // Never negative: pop implies occ >= 1.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign issue = (state == S_SCAN) && !abort && (rd_left != '0) && (pending < 3'd2);
    assign push  = (state == S_SCAN) && !abort && inflight;

    assign bus.rom_en   = issue;
    assign bus.rom_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (pop && bus.pix_eof) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= ADDR0;
            rd_left  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            fifo_0   <= 16'h0000;
            fifo_1   <= 16'h0000;
            col      <= '0;
            row      <= '0;
        end else begin
            inflight <= issue;
            if (state == S_IDLE && start) begin
                addr_q  <= ADDR0;
                rd_left <= RD_TOTAL;
                occ     <= 2'd0;
                col     <= '0;
                row     <= '0;
            end else if (state == S_SCAN && abort) begin
                // Queued pairs are dropped; the read on the ROM is ignored
                // because inflight is not used outside SCAN.
                occ <= 2'd0;
            end else if (state == S_SCAN) begin
                if (issue) begin
                    addr_q  <= addr_q + ADDR_W'(2);
                    rd_left <= rd_left - RD_W'(1);
                end

                case ({push, pop})
                    2'b10: begin
                        if (occ == 2'd0) begin
                            fifo_0 <= bus.rom_data[15:0];
                        end else begin
                            fifo_1 <= bus.rom_data[15:0];
                        end
                        occ <= occ + 2'd1;
                    end
                    2'b01: begin
                        fifo_0 <= fifo_1;
                        occ    <= occ - 2'd1;
                    end
                    2'b11: begin
                        if (occ == 2'd1) begin
                            fifo_0 <= bus.rom_data[15:0];
                        end else begin
                            fifo_0 <= fifo_1;
                            fifo_1 <= bus.rom_data[15:0];
                        end
                    end
                    default: begin
                    end
                endcase

                if (pop) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
module tb_rom_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s = 1'b0, abort_s = 1'b0, busy_s, done_s;
    logic start_m = 1'b0, abort_m = 1'b0, busy_m, done_m;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rom_scan_ctrl_if #(.ADDR_W(19)) s_if ();
    rom_scan_ctrl_if #(.ADDR_W(19)) m_if ();

    // Small 4x2 frame at address 0
    rom_scan_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(19), .BASE_ADDR(0)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
        .busy(busy_s), .done(done_s), .bus(s_if)
    );

    // 32x6 frame at 0x100: 96 pairs, last read at 0x1BE
    rom_scan_ctrl #(.IMG_W(32), .IMG_H(6), .ADDR_W(19), .BASE_ADDR(256)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .abort(abort_m),
        .busy(busy_m), .done(done_m), .bus(m_if)
    );

    // ROM models: byte value = low 8 bits of its address, junk in [31:16]
    wire [18:0] s_a1 = s_if.rom_addr + 19'd1;
    wire [18:0] m_a1 = m_if.rom_addr + 19'd1;

    always @(posedge clk) begin
        s_if.rom_data <= s_if.rom_en ? {16'hA5A5, s_if.rom_addr[7:0], s_a1[7:0]} : 32'h0;
        m_if.rom_data <= m_if.rom_en ? {16'h5A5A, m_if.rom_addr[7:0], m_a1[7:0]} : 32'h0;
    end

    initial begin
        s_if.pix_ready = 1'b0;
        m_if.pix_ready = 1'b0;
    end

    // Outstanding-read checker: reads issued minus pairs accepted must stay <= 2
    int out_s = 0, out_m = 0;
    always @(negedge clk) begin
        #3;
        if (rst || !busy_s) begin
            if (!rst) begin
                vectors++;
                if (s_if.rom_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL s_rom_en_outside_scan got %b want 0", s_if.rom_en);
                end
            end
            out_s = 0;
        end else begin
            if (s_if.rom_en) begin
                vectors++;
                if (out_s - int'(s_if.pix_valid & s_if.pix_ready) >= 2) begin
                    miscompares++;
                    $display("FAIL s_issue_rule outstanding %0d want <2", out_s);
                end
            end
            out_s = out_s + int'(s_if.rom_en) - int'(s_if.pix_valid & s_if.pix_ready);
        end
        if (rst || !busy_m) begin
            if (!rst) begin
                vectors++;
                if (m_if.rom_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL m_rom_en_outside_scan got %b want 0", m_if.rom_en);
                end
            end
            out_m = 0;
        end else begin
            if (m_if.rom_en) begin
                vectors++;
                if (out_m - int'(m_if.pix_valid & m_if.pix_ready) >= 2) begin
                    miscompares++;
                    $display("FAIL m_issue_rule outstanding %0d want <2", out_m);
                end
            end
            out_m = out_m + int'(m_if.rom_en) - int'(m_if.pix_valid & m_if.pix_ready);
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        vectors += 8;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy_done got %b%b want 00", busy_s, done_s);
        end
        if (s_if.rom_en !== 1'b0) begin
            miscompares++; $display("FAIL reset_rom_en got %b want 0", s_if.rom_en);
        end
        if (s_if.rom_addr !== 19'd0) begin
            miscompares++; $display("FAIL reset_rom_addr got %h want 0", s_if.rom_addr);
        end
        if (s_if.pix_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_pix_valid got %b want 0", s_if.pix_valid);
        end
        if (s_if.pix_data !== 16'h0) begin
            miscompares++; $display("FAIL reset_pix_data got %h want 0", s_if.pix_data);
        end
        if ({s_if.pix_sof, s_if.pix_eol, s_if.pix_eof} !== 3'b000) begin
            miscompares++; $display("FAIL reset_markers got %b want 000",
                                    {s_if.pix_sof, s_if.pix_eol, s_if.pix_eof});
        end
        if (m_if.rom_addr !== 19'h100) begin
            miscompares++; $display("FAIL reset_m_rom_addr got %h want 100", m_if.rom_addr);
        end
        if (busy_m !== 1'b0 || m_if.pix_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_m_idle got %b%b want 00", busy_m, m_if.pix_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (busy_s !== 1'b0 || s_if.rom_en !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_idle got %b%b want 00", busy_s, s_if.rom_en);
        end
    endtask

    task automatic test_small_frame(input logic abort_with_start);
        logic       exp_en, exp_valid, exp_sof, exp_eol, exp_eof, exp_done, exp_busy;
        logic [7:0] b0, b1;
        int         k;
        @(negedge clk);
        start_s = 1'b1;
        abort_s = abort_with_start;
        s_if.pix_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            abort_s = 1'b0;
            #1;
            exp_en    = (c >= 1 && c <= 4);
            exp_valid = (c >= 3 && c <= 6);
            k         = c - 3;
            exp_sof   = exp_valid && (k == 0);
            exp_eol   = exp_valid && (k == 1 || k == 3);
            exp_eof   = exp_valid && (k == 3);
            exp_done  = (c == 7);
            exp_busy  = (c >= 1 && c <= 6);
            vectors += 5;
            if (s_if.rom_en !== exp_en) begin
                miscompares++; $display("FAIL small_rom_en c%0d got %b want %b", c, s_if.rom_en, exp_en);
            end
            if (exp_en && s_if.rom_addr !== 19'(2 * (c - 1))) begin
                miscompares++; $display("FAIL small_rom_addr c%0d got %0d want %0d", c, s_if.rom_addr, 2 * (c - 1));
            end
            if (s_if.pix_valid !== exp_valid) begin
                miscompares++; $display("FAIL small_pix_valid c%0d got %b want %b", c, s_if.pix_valid, exp_valid);
            end
            if ({s_if.pix_sof, s_if.pix_eol, s_if.pix_eof} !== {exp_sof, exp_eol, exp_eof}) begin
                miscompares++; $display("FAIL small_markers c%0d got %b want %b", c,
                                        {s_if.pix_sof, s_if.pix_eol, s_if.pix_eof}, {exp_sof, exp_eol, exp_eof});
            end
            if (done_s !== exp_done || busy_s !== exp_busy) begin
                miscompares++; $display("FAIL small_done_busy c%0d got %b%b want %b%b", c,
                                        done_s, busy_s, exp_done, exp_busy);
            end
            if (exp_valid) begin
                b0 = 8'(2 * k);
                b1 = 8'(2 * k + 1);
                vectors++;
                if (s_if.pix_data !== {b0, b1}) begin
                    miscompares++; $display("FAIL small_pix_data c%0d got %h want %h", c, s_if.pix_data, {b0, b1});
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int          nrd = 0, ntx = 0, ndone = 0, done_cyc = -1;
        logic [15:0] held;
        logic [7:0]  b0, b1;
        @(negedge clk);
        start_s = 1'b1;
        s_if.pix_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            s_if.pix_ready = !(c >= 3 && c <= 7);
            #1;
            if (c == 3) held = s_if.pix_data;
            if (c >= 4 && c <= 7) begin
                vectors += 3;
                if (s_if.rom_en !== 1'b0) begin
                    miscompares++; $display("FAIL bp_rom_en_stall c%0d got %b want 0", c, s_if.rom_en);
                end
                if (s_if.pix_valid !== 1'b1 || s_if.pix_data !== held) begin
                    miscompares++; $display("FAIL bp_hold c%0d got %b/%h want 1/%h", c,
                                            s_if.pix_valid, s_if.pix_data, held);
                end
                if (s_if.pix_sof !== 1'b1) begin
                    miscompares++; $display("FAIL bp_sof_hold c%0d got %b want 1", c, s_if.pix_sof);
                end
            end
            if (s_if.rom_en) begin
                vectors++;
                if (s_if.rom_addr !== 19'(2 * nrd)) begin
                    miscompares++; $display("FAIL bp_rom_addr got %0d want %0d", s_if.rom_addr, 2 * nrd);
                end
                nrd++;
            end
            if (s_if.pix_valid && s_if.pix_ready) begin
                b0 = 8'(2 * ntx);
                b1 = 8'(2 * ntx + 1);
                vectors++;
                if (s_if.pix_data !== {b0, b1}) begin
                    miscompares++; $display("FAIL bp_pix_data pair%0d got %h want %h", ntx, s_if.pix_data, {b0, b1});
                end
                ntx++;
            end
            if (done_s) begin
                ndone++;
                done_cyc = c;
            end
        end
        vectors += 4;
        if (ntx != 4) begin
            miscompares++; $display("FAIL bp_pair_count got %0d want 4", ntx);
        end
        if (nrd != 4) begin
            miscompares++; $display("FAIL bp_read_count got %0d want 4", nrd);
        end
        if (ndone != 1) begin
            miscompares++; $display("FAIL bp_done_count got %0d want 1", ndone);
        end
        if (done_cyc != 12) begin
            miscompares++; $display("FAIL bp_done_cycle got %0d want 12", done_cyc);
        end
    endtask

    task automatic test_abort;
        @(negedge clk);
        start_s = 1'b1;
        s_if.pix_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            abort_s = (c == 4);
            #1;
            if (c == 4) begin
                vectors++;
                if (s_if.rom_en !== 1'b0) begin
                    miscompares++; $display("FAIL abort_rom_en c4 got %b want 0", s_if.rom_en);
                end
            end
            if (c == 5) begin
                vectors++;
                if (busy_s !== 1'b0 || s_if.pix_valid !== 1'b0) begin
                    miscompares++; $display("FAIL abort_idle c5 got busy %b valid %b want 0 0",
                                            busy_s, s_if.pix_valid);
                end
            end
            if (c >= 5) begin
                vectors++;
                if (done_s !== 1'b0 || s_if.rom_en !== 1'b0) begin
                    miscompares++; $display("FAIL abort_quiet c%0d got done %b en %b want 0 0",
                                            c, done_s, s_if.rom_en);
                end
            end
        end
        abort_s = 1'b0;
        // Restart with abort also high: start must win
        test_small_frame(1'b1);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        start_s = 1'b1;
        s_if.pix_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            start_s = 1'b0;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (s_if.rom_en !== 1'b1 || s_if.pix_valid !== 1'b1) begin
            miscompares++; $display("FAIL arst_pre c3 got en %b valid %b want 1 1", s_if.rom_en, s_if.pix_valid);
        end
        #1 rst = 1'b1;
        #1;
        vectors += 4;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || s_if.rom_en !== 1'b0) begin
            miscompares++; $display("FAIL arst_ctrl got busy %b done %b en %b want 0 0 0",
                                    busy_s, done_s, s_if.rom_en);
        end
        if (s_if.rom_addr !== 19'd0) begin
            miscompares++; $display("FAIL arst_rom_addr got %0d want 0", s_if.rom_addr);
        end
        if (s_if.pix_valid !== 1'b0 || s_if.pix_data !== 16'h0) begin
            miscompares++; $display("FAIL arst_pix got %b/%h want 0/0000", s_if.pix_valid, s_if.pix_data);
        end
        if ({s_if.pix_sof, s_if.pix_eol, s_if.pix_eof} !== 3'b000) begin
            miscompares++; $display("FAIL arst_markers got %b want 000",
                                    {s_if.pix_sof, s_if.pix_eol, s_if.pix_eof});
        end
        #1 rst = 1'b0;
        for (int c = 4; c <= 12; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (s_if.rom_en !== 1'b0 || busy_s !== 1'b0 || s_if.pix_valid !== 1'b0 || done_s !== 1'b0) begin
                miscompares++; $display("FAIL arst_stays_idle c%0d got en %b busy %b valid %b done %b want 0 0 0 0",
                                        c, s_if.rom_en, busy_s, s_if.pix_valid, done_s);
            end
        end
    endtask

    task automatic test_ignored_start_random;
        int          k = 0, nrd = 0, frames = 0, cyc = 0;
        logic [18:0] a, a1, last_addr;
        logic        eof_prev = 1'b0;
        logic        exp_sof, exp_eol, exp_eof;
        last_addr = '0;
        while (frames < 2 && cyc < 3000) begin
            @(negedge clk);
            start_m = 1'b1;
            m_if.pix_ready = 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (eof_prev) begin
                vectors++;
                if (done_m !== 1'b1) begin
                    miscompares++; $display("FAIL rnd_done_after_eof got %b want 1", done_m);
                end
            end
            eof_prev = 1'b0;
            if (done_m) begin
                vectors += 3;
                if (k != 96) begin
                    miscompares++; $display("FAIL rnd_pairs_per_frame got %0d want 96", k);
                end
                if (nrd != 96) begin
                    miscompares++; $display("FAIL rnd_reads_per_frame got %0d want 96", nrd);
                end
                if (last_addr !== 19'h1BE) begin
                    miscompares++; $display("FAIL rnd_last_addr got %h want 1be", last_addr);
                end
                frames++;
                k = 0;
                nrd = 0;
            end
            if (m_if.rom_en) begin
                a = 19'h100 + 19'(2 * nrd);
                vectors++;
                if (m_if.rom_addr !== a) begin
                    miscompares++; $display("FAIL rnd_rom_addr got %h want %h", m_if.rom_addr, a);
                end
                last_addr = m_if.rom_addr;
                nrd++;
            end
            if (m_if.pix_valid && m_if.pix_ready) begin
                a       = 19'h100 + 19'(2 * k);
                a1      = a + 19'd1;
                exp_sof = (k == 0);
                exp_eol = ((k % 16) == 15);
                exp_eof = (k == 95);
                vectors += 2;
                if (m_if.pix_data !== {a[7:0], a1[7:0]}) begin
                    miscompares++; $display("FAIL rnd_pix_data pair%0d got %h want %h", k, m_if.pix_data, {a[7:0], a1[7:0]});
                end
                if ({m_if.pix_sof, m_if.pix_eol, m_if.pix_eof} !== {exp_sof, exp_eol, exp_eof}) begin
                    miscompares++; $display("FAIL rnd_markers pair%0d got %b want %b", k,
                                            {m_if.pix_sof, m_if.pix_eol, m_if.pix_eof}, {exp_sof, exp_eol, exp_eof});
                end
                eof_prev = exp_eof;
                k++;
            end
        end
        start_m = 1'b0;
        m_if.pix_ready = 1'b1;
        vectors++;
        if (frames != 2) begin
            miscompares++; $display("FAIL rnd_timeout frames got %0d want 2", frames);
        end
        repeat (5) begin
            @(negedge clk);
            #1;
            vectors++;
            if (busy_m !== 1'b0 || m_if.rom_en !== 1'b0) begin
                miscompares++; $display("FAIL rnd_idle_after got busy %b en %b want 0 0", busy_m, m_if.rom_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_small_frame(1'b0);
        test_backpressure();
        test_abort();
        test_async_reset();
        test_ignored_start_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
